// File: rtl/spdif_aes3_transmitter_pkg.sv
// Shared types and payload helper for the S/PDIF-AES3 transmitter.
// Pure declarations: no clocked logic and no flow control.
package spdif_aes3_transmitter_pkg;

    typedef enum logic [1:0] {PRE_Z, PRE_X, PRE_Y} preamble_sel_t;
    typedef enum logic [1:0] {DISABLED, WAIT_L, WAIT_R} seq_state_t;

    localparam int SF_PAYLOAD_W  = 28;
    localparam int AUDIO_FIELD_W = 24;

    // Slots 4..31: audio LSB-first, then V, U, C and an even-parity bit over the rest.
    function automatic logic [SF_PAYLOAD_W-1:0] build_payload(
        input logic [AUDIO_FIELD_W-1:0] audio,
        input logic                     v,
        input logic                     u,
        input logic                     c
    );
        logic [SF_PAYLOAD_W-2:0] d;
        d = {c, u, v, audio};
        return {^d, d};
    endfunction

endpackage

// File: rtl/spdif_sample_buf.sv
// One-entry stereo holding register, MSB-aligned into the 24-bit audio field; loads in 1 cycle.
// s_ready is low while full or while load is not enabled; the entry is released only by the free strobe.
module spdif_sample_buf
    import spdif_aes3_transmitter_pkg::*;
#(
    parameter int AUDIO_W = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_en,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [AUDIO_W-1:0]       s_left,
    input  logic [AUDIO_W-1:0]       s_right,
    input  logic                     free,
    output logic                     full,
    output logic [AUDIO_FIELD_W-1:0] buf_left,
    output logic [AUDIO_FIELD_W-1:0] buf_right
);

    localparam int PAD = AUDIO_FIELD_W - AUDIO_W;

    assign s_ready = load_en && !full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= 1'b0;
            buf_left  <= '0;
            buf_right <= '0;
        end else if (s_valid && s_ready) begin
            full      <= 1'b1;
            buf_left  <= AUDIO_FIELD_W'(s_left) << PAD;
            buf_right <= AUDIO_FIELD_W'(s_right) << PAD;
        end else if (free) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/spdif_frame_sequencer.sv
// Builds left/right subframes (preamble + 28 payload bits) for the serializer; response 1 cycle after sf_req.
// Source is backpressured through the one-entry buffer; a missing sample yields a V=1 silent frame.
module spdif_frame_sequencer
    import spdif_aes3_transmitter_pkg::*;
#(
    parameter int AUDIO_W   = 24,
    parameter int BLOCK_LEN = 192
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [AUDIO_W-1:0]      s_left,
    input  logic [AUDIO_W-1:0]      s_right,
    input  logic [BLOCK_LEN-1:0]    chan_status,
    input  logic                    user_bit,
    input  logic                    sf_req,
    output logic                    sf_valid,
    output logic [1:0]              sf_preamble,
    output logic [SF_PAYLOAD_W-1:0] sf_bits,
    output logic                    block_start,
    output logic                    underrun
);

    localparam int CNT_W = $clog2(BLOCK_LEN);

    seq_state_t                state;
    logic [CNT_W-1:0]          frame_cnt;
    logic                      use_buf;
    logic                      buf_full;
    logic                      buf_free;
    logic [AUDIO_FIELD_W-1:0]  buf_left;
    logic [AUDIO_FIELD_W-1:0]  buf_right;

    // Only a frame that actually consumed the buffer releases it, so a sample
    // arriving during an underrun frame is kept whole for the next frame.
    assign buf_free = (state == WAIT_R) && sf_req && use_buf;

    spdif_sample_buf #(.AUDIO_W(AUDIO_W)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (state != DISABLED),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_left    (s_left),
        .s_right   (s_right),
        .free      (buf_free),
        .full      (buf_full),
        .buf_left  (buf_left),
        .buf_right (buf_right)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= DISABLED;
            frame_cnt   <= '0;
            use_buf     <= 1'b0;
            sf_valid    <= 1'b0;
            sf_preamble <= '0;
            sf_bits     <= '0;
            block_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            sf_valid    <= 1'b0;
            block_start <= 1'b0;
            underrun    <= 1'b0;
            case (state)
                DISABLED: begin
                    if (en) begin
                        state     <= WAIT_L;
                        frame_cnt <= '0;
                    end
                end
                WAIT_L: begin
                    if (sf_req) begin
                        sf_valid    <= 1'b1;
                        sf_preamble <= (frame_cnt == '0) ? PRE_Z : PRE_X;
                        block_start <= (frame_cnt == '0);
                        underrun    <= !buf_full;
                        use_buf     <= buf_full;
                        sf_bits     <= build_payload(buf_full ? buf_left : '0, !buf_full,
                                                     user_bit, chan_status[frame_cnt]);
                        state       <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (sf_req) begin
                        sf_valid    <= 1'b1;
                        sf_preamble <= PRE_Y;
                        sf_bits     <= build_payload(use_buf ? buf_right : '0, !use_buf,
                                                     user_bit, chan_status[frame_cnt]);
                        frame_cnt   <= (frame_cnt == CNT_W'(BLOCK_LEN - 1)) ? '0 : frame_cnt + 1'b1;
                        state       <= en ? WAIT_L : DISABLED;
                    end
                end
                default: state <= DISABLED;
            endcase
        end
    end

endmodule

// File: tb/tb_spdif_frame_sequencer.sv
// Scoreboard bench: stimulus queues expected subframes, monitors pop and compare on sf_valid.
module tb_spdif_frame_sequencer;
    import spdif_aes3_transmitter_pkg::*;

    typedef struct {
        logic [1:0]  pre;
        logic [27:0] bits;
        logic        bs;
        logic        ur;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         s_valid = 1'b0;
    logic [23:0]  s_left = '0;
    logic [23:0]  s_right = '0;
    logic [191:0] chan_status = '0;
    logic         user_bit = 1'b0;
    logic         sf_req = 1'b0;
    logic         s_ready, sf_valid, block_start, underrun;
    logic [1:0]   sf_preamble;
    logic [27:0]  sf_bits;

    logic         en16 = 1'b0;
    logic         s_valid16 = 1'b0;
    logic [15:0]  s_left16 = '0;
    logic [15:0]  s_right16 = '0;
    logic [191:0] cs16 = '0;
    logic         user16 = 1'b0;
    logic         sf_req16 = 1'b0;
    logic         s_ready16, sf_valid16, block_start16, underrun16;
    logic [1:0]   sf_preamble16;
    logic [27:0]  sf_bits16;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t q16[$];

    spdif_frame_sequencer #(.AUDIO_W(24), .BLOCK_LEN(192)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .s_valid(s_valid), .s_ready(s_ready),
        .s_left(s_left), .s_right(s_right), .chan_status(chan_status), .user_bit(user_bit),
        .sf_req(sf_req), .sf_valid(sf_valid), .sf_preamble(sf_preamble), .sf_bits(sf_bits),
        .block_start(block_start), .underrun(underrun)
    );

    spdif_frame_sequencer #(.AUDIO_W(16), .BLOCK_LEN(192)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .en(en16), .s_valid(s_valid16), .s_ready(s_ready16),
        .s_left(s_left16), .s_right(s_right16), .chan_status(cs16), .user_bit(user16),
        .sf_req(sf_req16), .sf_valid(sf_valid16), .sf_preamble(sf_preamble16), .sf_bits(sf_bits16),
        .block_start(block_start16), .underrun(underrun16)
    );

    always #5 clk = ~clk;

    function automatic exp_t lit(input logic [1:0] pre, input logic [27:0] bits,
                                 input logic bs, input logic ur);
        exp_t e;
        e.pre = pre; e.bits = bits; e.bs = bs; e.ur = ur;
        return e;
    endfunction

    function automatic exp_t mk(input logic [1:0] pre, input logic [23:0] a, input logic v,
                                input logic u, input logic c, input logic bs, input logic ur);
        logic [26:0] d;
        d = {c, u, v, a};
        return lit(pre, {^d, d}, bs, ur);
    endfunction

    always @(negedge clk) begin
        if (sf_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sf_valid got pre=%0d bits=%h required no subframe",
                         sf_preamble, sf_bits);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({sf_preamble, sf_bits, block_start, underrun} !== {e.pre, e.bits, e.bs, e.ur}) begin
                    errors++;
                    $display("FAIL subframe got pre=%0d bits=%h bs=%b ur=%b required pre=%0d bits=%h bs=%b ur=%b",
                             sf_preamble, sf_bits, block_start, underrun, e.pre, e.bits, e.bs, e.ur);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (sf_valid16) begin
            checks++;
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sf_valid16 got pre=%0d bits=%h required no subframe",
                         sf_preamble16, sf_bits16);
            end else begin
                exp_t e;
                e = q16.pop_front();
                if ({sf_preamble16, sf_bits16, block_start16, underrun16} !== {e.pre, e.bits, e.bs, e.ur}) begin
                    errors++;
                    $display("FAIL subframe16 got pre=%0d bits=%h bs=%b ur=%b required pre=%0d bits=%h bs=%b ur=%b",
                             sf_preamble16, sf_bits16, block_start16, underrun16, e.pre, e.bits, e.bs, e.ur);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, exp);
        end
    endtask

    task automatic req;
        sf_req = 1'b1;
        tick;
        sf_req = 1'b0;
        tick;
    endtask

    task automatic req16;
        sf_req16 = 1'b1;
        tick;
        sf_req16 = 1'b0;
        tick;
    endtask

    task automatic offer(input logic [23:0] l, input logic [23:0] r);
        int n;
        n = 0;
        s_left  = l;
        s_right = r;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            tick;
            n++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL offer_timeout got s_ready=0 required s_ready=1 within 50 cycles");
        end
        tick;
        s_valid = 1'b0;
    endtask

    initial begin
        logic saw;
        int   n;
        logic [7:0]  fc;
        logic [23:0] l, r;

        tick;
        tick;
        chk("reset_outputs", 64'({sf_valid, block_start, underrun, sf_preamble, sf_bits}), 64'h0);
        chk("reset_s_ready", 64'(s_ready), 64'h0);
        rst_n = 1'b1;
        chan_status = 192'h1;
        tick;
        chk("disabled_s_ready", 64'(s_ready), 64'h0);
        en = 1'b1;
        tick;
        chk("enabled_s_ready", 64'(s_ready), 64'h1);

        // Frame 0 and frame 1 with hand-computed payloads
        offer(24'h123456, 24'hFFFFFF);
        q.push_back(lit(PRE_Z, 28'h4123456, 1'b1, 1'b0)); req;
        q.push_back(lit(PRE_Y, 28'hCFFFFFF, 1'b0, 1'b0)); req;
        offer(24'h000001, 24'h000003);
        q.push_back(lit(PRE_X, 28'h8000001, 1'b0, 1'b0)); req;
        q.push_back(lit(PRE_Y, 28'h0000003, 1'b0, 1'b0)); req;

        // Continuous frames through the block wrap (frame 192 is Z again)
        for (int f = 2; f < 194; f++) begin
            fc = 8'(f % 192);
            l  = {8'h5A, 16'(f)};
            r  = {8'hC3, ~16'(f)};
            offer(l, r);
            q.push_back(mk((fc == 0) ? PRE_Z : PRE_X, l, 1'b0, 1'b0, fc == 0, fc == 0, 1'b0)); req;
            q.push_back(mk(PRE_Y, r, 1'b0, 1'b0, fc == 0, 1'b0, 1'b0)); req;
        end

        // Underrun frame; a sample arriving mid-frame waits for the next frame
        user_bit = 1'b1;
        q.push_back(lit(PRE_X, 28'h3000000, 1'b0, 1'b1)); req;
        offer(24'h00000F, 24'h0000F0);
        q.push_back(lit(PRE_Y, 28'h3000000, 1'b0, 1'b0)); req;
        user_bit = 1'b0;
        chk("held_sample_blocks_ready", 64'(s_ready), 64'h0);
        q.push_back(lit(PRE_X, 28'h000000F, 1'b0, 1'b0)); req;
        q.push_back(lit(PRE_Y, 28'h00000F0, 1'b0, 1'b0)); req;
        chk("ready_after_free", 64'(s_ready), 64'h1);

        // en drops between left and right: right still issued, then disabled
        offer(24'h800000, 24'h000001);
        q.push_back(lit(PRE_X, 28'h8800000, 1'b0, 1'b0)); req;
        en = 1'b0;
        q.push_back(lit(PRE_Y, 28'h8000001, 1'b0, 1'b0)); req;
        tick;
        chk("after_en_drop_s_ready", 64'(s_ready), 64'h0);
        saw = 1'b0;
        sf_req = 1'b1;
        tick;
        sf_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sf_valid) saw = 1'b1;
        end
        tick;
        chk("no_valid_when_disabled", 64'(saw), 64'h0);

        // Reset while a subframe response is on the outputs
        en = 1'b1;
        tick;
        offer(24'h0000AA, 24'h000055);
        sf_req = 1'b1;
        tick;
        sf_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("reset_midframe_outputs", 64'({sf_valid, block_start, underrun, sf_preamble, sf_bits}), 64'h0);
        chk("reset_midframe_s_ready", 64'(s_ready), 64'h0);
        tick;
        rst_n = 1'b1;
        tick;
        tick;
        offer(24'h000007, 24'h000000);
        q.push_back(lit(PRE_Z, 28'h4000007, 1'b1, 1'b0)); req;
        q.push_back(lit(PRE_Y, 28'hC000000, 1'b0, 1'b0)); req;

        // 16-bit samples are MSB-aligned in the 24-bit audio field
        en16 = 1'b1;
        tick;
        s_left16  = 16'h8001;
        s_right16 = 16'h0001;
        s_valid16 = 1'b1;
        n = 0;
        while (!s_ready16 && n < 50) begin
            tick;
            n++;
        end
        chk("ready16", 64'(s_ready16), 64'h1);
        tick;
        s_valid16 = 1'b0;
        q16.push_back(lit(PRE_Z, 28'h0800100, 1'b1, 1'b0)); req16;
        q16.push_back(lit(PRE_Y, 28'h8000100, 1'b0, 1'b0)); req16;

        repeat (3) tick;
        chk("main_queue_drained", 64'(q.size()), 64'h0);
        chk("q16_drained", 64'(q16.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
